// File: rtl/ld_violation_reporter.sv
// Load-violation reporter: holds the oldest LSQ-flagged violation and broadcasts
// a one-cycle recovery carrying its PC once the load reaches the active-list head.
module ld_violation_reporter #(
  parameter int AL_IDX_W     = 7,
  parameter int PC_W         = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vioValid_i,
  input  logic [AL_IDX_W-1:0] vioAlId_i,
  input  logic [PC_W-1:0]     vioPc_i,
  input  logic [AL_IDX_W-1:0] alHead_i,
  input  logic                headValid_i,
  input  logic                extRecover_i,
  input  logic [AL_IDX_W-1:0] extAlId_i,
  output logic                loadViolation_o,
  output logic                recoverFlag_o,
  output logic [PC_W-1:0]     recoverPC_o,
  output logic                pending_o,
  output logic [CNT_W-1:0]    vioCount_o
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PENDING, BCAST, DRAIN} stateT;

  stateT               state, nextState;
  logic [AL_IDX_W-1:0] heldId, nextHeldId;
  logic [PC_W-1:0]     heldPc, nextHeldPc;
  logic [DRAIN_W-1:0]  drainCnt, nextDrainCnt;

  logic [AL_IDX_W-1:0] vioAge, extAge, heldAge;
  logic                vioSurvives, heldCleared, headMatch;

  logic                nextLv, nextPending;
  logic [PC_W-1:0]     nextRecoverPc;
  logic [CNT_W-1:0]    nextCount;

  // Ages relative to the current head; modular subtraction absorbs wrap-around.
  assign vioAge      = vioAlId_i - alHead_i;
  assign extAge      = extAlId_i - alHead_i;
  assign heldAge     = heldId - alHead_i;
  assign vioSurvives = vioValid_i && !(extRecover_i && (vioAge > extAge));
  assign heldCleared = extRecover_i && (heldAge > extAge);
  assign headMatch   = headValid_i && (alHead_i == heldId);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      heldId          <= '0;
      heldPc          <= '0;
      drainCnt        <= '0;
      loadViolation_o <= 1'b0;
      recoverFlag_o   <= 1'b0;
      recoverPC_o     <= '0;
      pending_o       <= 1'b0;
      vioCount_o      <= '0;
    end else begin
      state           <= nextState;
      heldId          <= nextHeldId;
      heldPc          <= nextHeldPc;
      drainCnt        <= nextDrainCnt;
      loadViolation_o <= nextLv;
      recoverFlag_o   <= nextLv;
      recoverPC_o     <= nextRecoverPc;
      pending_o       <= nextPending;
      vioCount_o      <= nextCount;
    end
  end

  always_comb begin
    nextState    = state;
    nextHeldId   = heldId;
    nextHeldPc   = heldPc;
    nextDrainCnt = drainCnt;
    case (state)
      IDLE: begin
        if (vioSurvives) begin
          nextHeldId = vioAlId_i;
          nextHeldPc = vioPc_i;
          nextState  = PENDING;
        end
      end
      PENDING: begin
        // A branch recovery older than the held load wins over everything else.
        if (heldCleared) begin
          if (vioSurvives) begin
            nextHeldId = vioAlId_i;
            nextHeldPc = vioPc_i;
          end else begin
            nextState = IDLE;
          end
        end else if (headMatch) begin
          nextState = BCAST;
        end else if (vioSurvives && (vioAge < heldAge)) begin
          nextHeldId = vioAlId_i;
          nextHeldPc = vioPc_i;
        end
      end
      BCAST: begin
        nextHeldId   = '0;
        nextHeldPc   = '0;
        nextDrainCnt = DRAIN_W'(DRAIN_CYCLES);
        nextState    = DRAIN;
      end
      DRAIN: begin
        if (drainCnt <= DRAIN_W'(1)) begin
          nextDrainCnt = '0;
          nextState    = IDLE;
        end else begin
          nextDrainCnt = drainCnt - DRAIN_W'(1);
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    nextLv        = (nextState == BCAST);
    nextPending   = (nextState == PENDING);
    nextRecoverPc = nextLv ? heldPc : '0;
    nextCount     = vioCount_o;
    if (nextLv && (vioCount_o != {CNT_W{1'b1}})) begin
      nextCount = vioCount_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ld_violation_reporter.sv
// Directed bench for ld_violation_reporter: a cycle-by-cycle vector table plus
// hand-written sequences for reset-in-broadcast and counter saturation.
module tb_ld_violation_reporter;

  logic        clk;
  logic        reset;
  logic        vioValid;
  logic [6:0]  vioAlId;
  logic [31:0] vioPc;
  logic [6:0]  alHead;
  logic        headValid;
  logic        extRecover;
  logic [6:0]  extAlId;

  logic        loadViolation, recoverFlag, pending;
  logic [31:0] recoverPC;
  logic [15:0] vioCount;

  logic        smallLv, smallFlag, smallPending;
  logic [31:0] smallPC;
  logic [2:0]  smallCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vioValid;
    logic [6:0]  vioAlId;
    logic [31:0] vioPc;
    logic [6:0]  alHead;
    logic        headValid;
    logic        extRecover;
    logic [6:0]  extAlId;
    logic        expLv;
    logic [31:0] expPc;
    logic        expPending;
    int          expCount;
  } vecT;

  vecT vecs[$];

  ld_violation_reporter dut (
    .clk(clk), .reset(reset),
    .vioValid_i(vioValid), .vioAlId_i(vioAlId), .vioPc_i(vioPc),
    .alHead_i(alHead), .headValid_i(headValid),
    .extRecover_i(extRecover), .extAlId_i(extAlId),
    .loadViolation_o(loadViolation), .recoverFlag_o(recoverFlag),
    .recoverPC_o(recoverPC), .pending_o(pending), .vioCount_o(vioCount)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  ld_violation_reporter #(.CNT_W(3)) dutSmall (
    .clk(clk), .reset(reset),
    .vioValid_i(vioValid), .vioAlId_i(vioAlId), .vioPc_i(vioPc),
    .alHead_i(alHead), .headValid_i(headValid),
    .extRecover_i(extRecover), .extAlId_i(extAlId),
    .loadViolation_o(smallLv), .recoverFlag_o(smallFlag),
    .recoverPC_o(smallPC), .pending_o(smallPending), .vioCount_o(smallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vecT mkVec(input logic vv, input int vid, input logic [31:0] vpc,
                                input int head, input logic hv, input logic er, input int eid,
                                input logic eLv, input logic [31:0] ePc, input logic ePend,
                                input int eCnt);
    vecT v;
    v.vioValid   = vv;
    v.vioAlId    = 7'(vid);
    v.vioPc      = vpc;
    v.alHead     = 7'(head);
    v.headValid  = hv;
    v.extRecover = er;
    v.extAlId    = 7'(eid);
    v.expLv      = eLv;
    v.expPc      = ePc;
    v.expPending = ePend;
    v.expCount   = eCnt;
    return v;
  endfunction

  task automatic addVec(input logic vv, input int vid, input logic [31:0] vpc,
                        input int head, input logic hv, input logic er, input int eid,
                        input logic eLv, input logic [31:0] ePc, input logic ePend,
                        input int eCnt);
    vecs.push_back(mkVec(vv, vid, vpc, head, hv, er, eid, eLv, ePc, ePend, eCnt));
  endtask

  // BCAST-to-DRAIN edge plus four drain cycles, then the FSM is back in IDLE.
  task automatic addDrain(input int head, input int cnt);
    for (int k = 0; k < 5; k++) addVec(0, 0, 0, head, 0, 0, 0, 0, 0, 0, cnt);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input vecT v);
    vioValid   = v.vioValid;
    vioAlId    = v.vioAlId;
    vioPc      = v.vioPc;
    alHead     = v.alHead;
    headValid  = v.headValid;
    extRecover = v.extRecover;
    extAlId    = v.extAlId;
  endtask

  task automatic checkOutput(input string name, input vecT v);
    int smallExp;
    smallExp = (v.expCount > 7) ? 7 : v.expCount;
    cmp({name, ".loadViolation"}, 32'(loadViolation), 32'(v.expLv));
    cmp({name, ".recoverFlag"},   32'(recoverFlag),   32'(v.expLv));
    cmp({name, ".recoverPC"},     recoverPC,          v.expPc);
    cmp({name, ".pending"},       32'(pending),       32'(v.expPending));
    cmp({name, ".vioCount"},      32'(vioCount),      32'(v.expCount));
    cmp({name, ".smallCount"},    32'(smallCount),    32'(smallExp));
  endtask

  task automatic doCycle(input string name, input vecT v);
    @(negedge clk);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(name, v);
  endtask

  initial begin
    // Oldest-wins, head match, drain window with vio every cycle, recapture after drain.
    addVec(1, 12, 32'h1000, 10, 0, 0, 0,  0, 0, 1, 0);
    addVec(0, 0, 0,         11, 1, 0, 0,  0, 0, 1, 0);
    addVec(0, 0, 0,         12, 1, 0, 0,  1, 32'h1000, 0, 1);
    for (int k = 0; k < 5; k++) addVec(1, 14, 32'h1400, 13, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 14, 32'h1400, 13, 0, 0, 0,  0, 0, 1, 1);
    addVec(0, 0, 0,         14, 1, 0, 0,  1, 32'h1400, 0, 2);
    addDrain(14, 2);
    // Replace by older, drop younger, no broadcast without headValid.
    addVec(1, 20, 32'hA0, 5, 0, 0, 0,  0, 0, 1, 2);
    addVec(1, 8,  32'hB0, 5, 0, 0, 0,  0, 0, 1, 2);
    addVec(1, 15, 32'hC0, 5, 0, 0, 0,  0, 0, 1, 2);
    addVec(0, 0, 0,       8, 0, 0, 0,  0, 0, 1, 2);
    addVec(1, 9,  32'hD0, 8, 1, 0, 0,  1, 32'hB0, 0, 3);
    addDrain(8, 3);
    // Wrap-around: id 3 has age 11 against held age 5 and is dropped.
    addVec(1, 125, 32'h125, 120, 0, 0, 0,  0, 0, 1, 3);
    addVec(1, 3,   32'h3,   120, 0, 0, 0,  0, 0, 1, 3);
    addVec(0, 0, 0,         125, 1, 0, 0,  1, 32'h125, 0, 4);
    addDrain(125, 4);
    // External recovery older than held clears it; younger keeps it.
    addVec(1, 30, 32'h30, 25, 0, 0, 0,   0, 0, 1, 4);
    addVec(0, 0, 0,       25, 0, 1, 28,  0, 0, 0, 4);
    addVec(0, 0, 0,       30, 1, 0, 0,   0, 0, 0, 4);
    addVec(1, 30, 32'h31, 25, 0, 0, 0,   0, 0, 1, 4);
    addVec(0, 0, 0,       25, 0, 1, 32,  0, 0, 1, 4);
    addVec(0, 0, 0,       30, 1, 0, 0,   1, 32'h31, 0, 5);
    addDrain(30, 5);
    // Same-cycle ext filter in IDLE, then clear-and-recapture in PENDING.
    addVec(1, 40, 32'h40, 30, 0, 1, 35,  0, 0, 0, 5);
    addVec(1, 40, 32'h40, 30, 0, 0, 0,   0, 0, 1, 5);
    addVec(1, 33, 32'h33, 30, 0, 1, 38,  0, 0, 1, 5);
    addVec(0, 0, 0,       40, 1, 0, 0,   0, 0, 1, 5);
    addVec(0, 0, 0,       33, 1, 0, 0,   1, 32'h33, 0, 6);
    addDrain(33, 6);

    reset = 1'b0;
    applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) doCycle($sformatf("vec%0d", i), vecs[i]);

    // Reset taken while the broadcast is on the outputs.
    doCycle("rstCapture", mkVec(1, 50, 32'h50, 45, 0, 0, 0, 0, 0, 1, 6));
    doCycle("rstBcast",   mkVec(0, 0, 0, 50, 1, 0, 0, 1, 32'h50, 0, 7));
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(mkVec(0, 0, 0, 50, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("rstInBcast", mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    doCycle("postRstCapture", mkVec(1, 60, 32'h60, 55, 0, 0, 0, 0, 0, 1, 0));
    doCycle("postRstBcast",   mkVec(0, 0, 0, 60, 1, 0, 0, 1, 32'h60, 0, 1));
    for (int k = 0; k < 5; k++)
      doCycle($sformatf("postRstDrain%0d", k), mkVec(0, 0, 0, 60, 0, 0, 0, 0, 0, 0, 1));

    // Repeated broadcasts: wide counter keeps counting, narrow one sticks at 7.
    for (int n = 2; n <= 9; n++) begin
      doCycle($sformatf("satCapture%0d", n),
              mkVec(1, n + 10, 32'h100 + 32'(n), n + 9, 0, 0, 0, 0, 0, 1, n - 1));
      doCycle($sformatf("satBcast%0d", n),
              mkVec(0, 0, 0, n + 10, 1, 0, 0, 1, 32'h100 + 32'(n), 0, n));
      for (int k = 0; k < 5; k++)
        doCycle($sformatf("satDrain%0d_%0d", n, k),
                mkVec(0, 0, 0, n + 10, 0, 0, 0, 0, 0, 0, n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ld_violation_reporter.md
Name: ld_violation_reporter

Overview:
- Producer side of the load-violation broadcast consumed by the dispatch-stage load-violation predictor and the recovery logic.
- Collects memory-order violations flagged by the LSQ and keeps only the oldest one pending.
- When the violating load reaches the active-list head, issues a single-cycle load-violation recovery broadcast carrying its PC.
- Then holds off new reports for a fixed drain window while the pipeline squashes.

Parameters:
AL_IDX_W, 7, active-list index width (2^AL_IDX_W entries)
PC_W, 32, PC width; matches SIZE_PC
DRAIN_CYCLES, 4, cycles after a broadcast during which vio inputs are ignored (≥1)
CNT_W, 16, width of the saturating broadcast counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset
vioValid_i  in  1  LSQ reports a violating load this cycle
vioAlId_i  in  AL_IDX_W  active-list ID of the violating load
vioPc_i  in  PC_W  PC of the violating load
alHead_i  in  AL_IDX_W  current active-list head ID
headValid_i  in  1  head entry valid and completed
extRecover_i  in  1  other recovery (branch mispredict) this cycle
extAlId_i  in  AL_IDX_W  active-list ID of the mispredicting instruction
loadViolation_o  out  1  load-violation broadcast (one cycle)
recoverFlag_o  out  1  recovery request, asserted together with loadViolation_o
recoverPC_o  out  PC_W  PC of the violating load during broadcast, else 0
pending_o  out  1  a violation is held
vioCount_o  out  CNT_W  saturating count of broadcasts issued

Behaviour:
- All outputs registered. On reset low at a clk edge: state=IDLE; held entry invalid; held ID/PC=0; drain counter=0; all outputs 0.
- Age(x) = (x − alHead_i) mod 2^AL_IDX_W, evaluated with the current alHead_i. A smaller age is older. Wrap-around is handled only by this subtraction.
- State IDLE:
  - vioValid_i captures ID/PC; next state PENDING.
  - extRecover_i in the same cycle drops the capture if Age(vioAlId_i) > Age(extAlId_i).
- State PENDING:
  - New vio with Age(vioAlId_i) < Age(heldId) replaces the held entry. Equal or younger is dropped.
  - extRecover_i with Age(heldId) > Age(extAlId_i) invalidates the held entry (→IDLE). An incoming vio in that cycle obeys the same younger-than-branch filter, and a surviving one is captured.
  - Priority: external-recovery clear, then head match, then replace.
  - Head match: headValid_i=1 and alHead_i==heldId, and the entry not cleared that cycle. Next state BCAST. Any vio arriving that cycle is dropped.
- State BCAST (exactly one cycle):
  - loadViolation_o=1, recoverFlag_o=1, recoverPC_o=heldPc.
  - vioCount_o increments, saturating at 2^CNT_W−1.
  - Held entry invalidated. Drain counter loaded with DRAIN_CYCLES. Next state DRAIN.
- State DRAIN:
  - All vio and extRecover inputs are ignored.
  - Counter decrements each cycle; at 1 → IDLE. Total ignore window is DRAIN_CYCLES cycles after BCAST.
- pending_o=1 in PENDING only.
- loadViolation_o and recoverFlag_o are never asserted on back-to-back cycles. Minimum spacing is DRAIN_CYCLES+1.
- Reset low in any state (including BCAST/DRAIN) returns to the reset values on that edge. No broadcast is emitted.

Test Plan:
1. Reset, alHead_i=10, vio id=12 pc=0x1000. Advance head to 12 with headValid_i=1 → one-cycle loadViolation_o=recoverFlag_o=1, recoverPC_o=0x1000; vioCount_o=1; no new report accepted for 4 cycles.
2. Head=5, vio id=20 pc=0xA0, then vio id=8 pc=0xB0 → held replaced by id 8. Then vio id=15 → dropped. Broadcast PC=0xB0 when head=8.
3. Wrap-around: head=120, held id=125, new vio id=3 → id 3 dropped (age 11 > 5). Head=125 → broadcast held PC.
4. Held id=30, head=25, extRecover_i id=28 → held cleared, pending_o=0, no broadcast. With ext id=32 instead → held kept, broadcast at head=30.
5. During DRAIN, vio id=head+1 each cycle → all ignored. First vio after the drain window is captured, pending_o=1.
6. Reset low while in BCAST → outputs 0 next cycle, vioCount_o=0, state IDLE. Separately, preload vioCount_o to 0xFFFF via 65535 broadcasts (or force) → it stays 0xFFFF.
